// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake and decoded field bundle of decode_stage.
// slave is the stage side, master the fetch/execute side.
interface decode_stage_if #(
   parameter int PC_WIDTH = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         insn;
   logic [PC_WIDTH-1:0] pc;
   logic                out_valid;
   logic                out_ready;
   logic [5:0]          opcode_out;
   logic [5:0]          func_out;
   logic [4:0]          rs_out;
   logic [4:0]          rt_out;
   logic [4:0]          rd_out;
   logic [4:0]          sa_out;
   logic [31:0]         imm_out;
   logic [PC_WIDTH-1:0] target_out;
   logic [PC_WIDTH-1:0] pc_out;
   logic [4:0]          wreg_out;
   logic [2:0]          class_out;
   logic                illegal_out;

   modport slave (
      input  in_valid, insn, pc, out_ready,
      output in_ready, out_valid,
      output opcode_out, func_out,
      output rs_out, rt_out, rd_out, sa_out,
      output imm_out, target_out, pc_out,
      output wreg_out, class_out, illegal_out
   );

   modport master (
      output in_valid, insn, pc, out_ready,
      input  in_ready, out_valid,
      input  opcode_out, func_out,
      input  rs_out, rt_out, rd_out, sa_out,
      input  imm_out, target_out, pc_out,
      input  wreg_out, class_out, illegal_out
   );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: field extraction, immediate/target generation,
// classification, with optional two-entry skid buffer on the output.
module decode_stage #(
   parameter int PC_WIDTH = 32,
   parameter bit SKID_EN  = 1'b1
) (
   input logic           clock,
   input logic           reset,
   input logic           flush,
   decode_stage_if.slave bus
);
   typedef enum logic [2:0] {
      C_ALU_R, C_ALU_I, C_LOAD, C_STORE,
      C_BRANCH, C_JUMP, C_MULDIV, C_ILLEGAL
   } class_e;

   typedef struct packed {
      logic [5:0]          opcode;
      logic [5:0]          func;
      logic [4:0]          rs;
      logic [4:0]          rt;
      logic [4:0]          rd;
      logic [4:0]          sa;
      logic [31:0]         imm;
      logic [PC_WIDTH-1:0] target;
      logic [PC_WIDTH-1:0] pc;
      logic [4:0]          wreg;
      class_e              cls;
   } entry_t;

   entry_t              d, m, s;
   logic                m_valid, s_valid;
   logic                s_valid_nxt, rdy_q;
   logic                accept, m_load;
   logic [15:0]         imm16;
   logic [PC_WIDTH-1:0] pc4, br_tgt, j_tgt;

   always_comb begin
      d        = '0;
      imm16    = bus.insn[15:0];
      d.opcode = bus.insn[31:26];
      d.func   = bus.insn[5:0];
      d.rs     = bus.insn[25:21];
      d.rt     = bus.insn[20:16];
      d.rd     = bus.insn[15:11];
      d.sa     = bus.insn[10:6];
      d.imm    = {{16{imm16[15]}}, imm16};
      d.pc     = bus.pc;
      d.cls    = C_ILLEGAL;
      pc4      = bus.pc + PC_WIDTH'(4);
      br_tgt   = pc4 + {d.imm[PC_WIDTH-3:0], 2'b00};
      // jump keeps the upper pc bits above the 256MB region
      j_tgt        = pc4;
      j_tgt[27:0]  = {bus.insn[25:0], 2'b00};
      unique case (d.opcode)
         6'h00: begin
            unique case (d.func)
               6'h00, 6'h02, 6'h03, 6'h04,
               6'h06, 6'h07, 6'h10, 6'h12,
               6'h20, 6'h21, 6'h22, 6'h23,
               6'h24, 6'h25, 6'h26, 6'h27,
               6'h2a, 6'h2b: begin
                  d.cls  = C_ALU_R;
                  d.wreg = d.rd;
               end
               6'h18, 6'h19, 6'h1a, 6'h1b:
                  d.cls = C_MULDIV;
               6'h08: d.cls = C_JUMP;
               6'h09: begin
                  d.cls  = C_JUMP;
                  d.wreg = d.rd;
               end
               default: d.cls = C_ILLEGAL;
            endcase
         end
         6'h01: begin
            if (d.rt[4:1] == 4'd0) begin
               d.cls    = C_BRANCH;
               d.target = br_tgt;
            end
         end
         6'h02: begin
            d.cls    = C_JUMP;
            d.target = j_tgt;
         end
         6'h03: begin
            d.cls    = C_JUMP;
            d.target = j_tgt;
            d.wreg   = 5'd31;
         end
         6'h04, 6'h05, 6'h06, 6'h07: begin
            d.cls    = C_BRANCH;
            d.target = br_tgt;
         end
         6'h08, 6'h09, 6'h0a, 6'h0b: begin
            d.cls  = C_ALU_I;
            d.wreg = d.rt;
         end
         6'h0c, 6'h0d, 6'h0e: begin
            d.cls  = C_ALU_I;
            d.wreg = d.rt;
            d.imm  = {16'h0, imm16};
         end
         6'h0f: begin
            d.cls  = C_ALU_I;
            d.wreg = d.rt;
            d.imm  = {imm16, 16'h0};
         end
         6'h20, 6'h23, 6'h24: begin
            d.cls  = C_LOAD;
            d.wreg = d.rt;
         end
         6'h28, 6'h2b: d.cls = C_STORE;
         default:      d.cls = C_ILLEGAL;
      endcase
   end

   assign accept = bus.in_valid && bus.in_ready && !flush;
   assign m_load = !m_valid || bus.out_ready;
   // S only ever fills while M is stalled
   assign s_valid_nxt = m_load ? 1'b0 : (s_valid || accept);
   assign bus.in_ready = SKID_EN ? rdy_q : m_load;

   always_ff @(posedge clock) begin
      if (reset) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         rdy_q   <= 1'b0;
         m       <= '0;
         s       <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         s_valid <= s_valid_nxt;
         rdy_q   <= !s_valid_nxt;
         if (m_load) begin
            if (s_valid) begin
               m       <= s;
               m_valid <= 1'b1;
            end else begin
               m_valid <= accept;
               if (accept) m <= d;
            end
         end else if (accept) begin
            s <= d;
         end
      end
   end

   assign bus.out_valid   = m_valid;
   assign bus.opcode_out  = m.opcode;
   assign bus.func_out    = m.func;
   assign bus.rs_out      = m.rs;
   assign bus.rt_out      = m.rt;
   assign bus.rd_out      = m.rd;
   assign bus.sa_out      = m.sa;
   assign bus.imm_out     = m.imm;
   assign bus.target_out  = m.target;
   assign bus.pc_out      = m.pc;
   assign bus.wreg_out    = m.wreg;
   assign bus.class_out   = m.cls;
   assign bus.illegal_out = (m.cls == C_ILLEGAL);
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: skid and non-skid instances on shared stimulus,
// checked every cycle against a FIFO-level behavioural model.
module tb_decode_stage;
   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sa;
      logic [31:0] imm;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic [4:0]  wreg;
      logic [2:0]  cls;
   } exp_t;

   localparam logic [5:0] RF [25] = '{
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
      6'h09, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
      6'h27, 6'h2a, 6'h2b, 6'h05
   };
   localparam logic [5:0] IOPS [20] = '{
      6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
      6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
      6'h20, 6'h23, 6'h24, 6'h28, 6'h2b, 6'h3f
   };

   logic        clock = 1'b0;
   logic        reset, flush;
   logic        in_valid, out_ready;
   logic [31:0] insn, pc;

   int errors = 0;
   int checks = 0;

   decode_stage_if #(.PC_WIDTH(32)) b0 ();
   decode_stage_if #(.PC_WIDTH(32)) b1 ();

   assign b0.in_valid  = in_valid;
   assign b0.insn      = insn;
   assign b0.pc        = pc;
   assign b0.out_ready = out_ready;
   assign b1.in_valid  = in_valid;
   assign b1.insn      = insn;
   assign b1.pc        = pc;
   assign b1.out_ready = out_ready;

   decode_stage #(.PC_WIDTH(32), .SKID_EN(1'b1)) u_skid (
      .clock(clock), .reset(reset), .flush(flush), .bus(b0)
   );
   decode_stage #(.PC_WIDTH(32), .SKID_EN(1'b0)) u_nosk (
      .clock(clock), .reset(reset), .flush(flush), .bus(b1)
   );

   always #5 clock = ~clock;

   task automatic ck(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic exp_t ref_decode(logic [31:0] w, logic [31:0] p);
      exp_t e;
      logic [31:0] nxt;
      e     = '0;
      e.op  = w[31:26];
      e.fn  = w[5:0];
      e.rs  = w[25:21];
      e.rt  = w[20:16];
      e.rd  = w[15:11];
      e.sa  = w[10:6];
      e.pc  = p;
      e.imm = {{16{w[15]}}, w[15:0]};
      e.cls = 3'd7;
      nxt   = p + 32'd4;
      if (e.op == 6'h00) begin
         if (e.fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                          6'h10, 6'h12, [6'h20:6'h27], 6'h2a, 6'h2b}) begin
            e.cls  = 3'd0;
            e.wreg = e.rd;
         end else if (e.fn inside {[6'h18:6'h1b]}) begin
            e.cls = 3'd6;
         end else if (e.fn == 6'h08) begin
            e.cls = 3'd5;
         end else if (e.fn == 6'h09) begin
            e.cls  = 3'd5;
            e.wreg = e.rd;
         end
      end else if (e.op inside {[6'h04:6'h07]} ||
                   (e.op == 6'h01 && e.rt < 5'd2)) begin
         e.cls = 3'd4;
         e.tgt = nxt + e.imm * 32'd4;
      end else if (e.op == 6'h02 || e.op == 6'h03) begin
         e.cls = 3'd5;
         e.tgt = {nxt[31:28], w[25:0], 2'b00};
         if (e.op == 6'h03) e.wreg = 5'd31;
      end else if (e.op inside {[6'h08:6'h0f]}) begin
         e.cls  = 3'd1;
         e.wreg = e.rt;
         if (e.op inside {[6'h0c:6'h0e]}) e.imm = {16'h0, w[15:0]};
         if (e.op == 6'h0f) e.imm = {w[15:0], 16'h0};
      end else if (e.op inside {6'h20, 6'h23, 6'h24}) begin
         e.cls  = 3'd2;
         e.wreg = e.rt;
      end else if (e.op inside {6'h28, 6'h2b}) begin
         e.cls = 3'd3;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_insn();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k <= 3) begin
         w[31:26] = 6'h00;
         w[5:0]   = RF[$urandom_range(0, 24)];
      end else if (k == 4) begin
         w[31:26] = 6'h01;
         w[20:16] = 5'($urandom_range(0, 3));
      end else if (k < 9) begin
         w[31:26] = IOPS[$urandom_range(0, 19)];
      end
      return w;
   endfunction

   // Model: the stage is a FIFO (depth 2 with skid, 1 without)
   exp_t q0[$], q1[$];
   bit   rst_last = 1'b1;
   bit   z0 = 1'b1, z1 = 1'b1;
   bit   started = 1'b0;
   exp_t a0, a1;
   exp_t zero_e = '0;

   always @(posedge clock) begin
      bit ir0, ir1;
      ir0 = !rst_last && q0.size() < 2;
      ir1 = q1.size() == 0 || out_ready;
      if (reset) begin
         q0.delete();
         q1.delete();
         z0 = 1'b1;
         z1 = 1'b1;
         rst_last = 1'b1;
      end else begin
         rst_last = 1'b0;
         if (flush) begin
            q0.delete();
            q1.delete();
         end else begin
            if (q0.size() > 0 && out_ready) void'(q0.pop_front());
            if (q1.size() > 0 && out_ready) void'(q1.pop_front());
            if (in_valid && ir0) begin
               q0.push_back(ref_decode(insn, pc));
               z0 = 1'b0;
            end
            if (in_valid && ir1) begin
               q1.push_back(ref_decode(insn, pc));
               z1 = 1'b0;
            end
         end
      end
   end

   always_comb begin
      a0 = '{b0.opcode_out, b0.func_out, b0.rs_out, b0.rt_out,
             b0.rd_out, b0.sa_out, b0.imm_out, b0.target_out,
             b0.pc_out, b0.wreg_out, b0.class_out};
      a1 = '{b1.opcode_out, b1.func_out, b1.rs_out, b1.rt_out,
             b1.rd_out, b1.sa_out, b1.imm_out, b1.target_out,
             b1.pc_out, b1.wreg_out, b1.class_out};
   end

   task automatic cmp(string t, exp_t a, logic ov, logic ir, logic ill,
                      exp_t h, int cnt, bit eir, bit zero);
      ck({t, ".in_ready"}, 32'(ir), 32'(eir));
      ck({t, ".out_valid"}, 32'(ov), 32'(cnt > 0));
      if (cnt > 0 || zero) begin
         ck({t, ".opcode"}, 32'(a.op), 32'(h.op));
         ck({t, ".func"}, 32'(a.fn), 32'(h.fn));
         ck({t, ".rs"}, 32'(a.rs), 32'(h.rs));
         ck({t, ".rt"}, 32'(a.rt), 32'(h.rt));
         ck({t, ".rd"}, 32'(a.rd), 32'(h.rd));
         ck({t, ".sa"}, 32'(a.sa), 32'(h.sa));
         ck({t, ".imm"}, a.imm, h.imm);
         ck({t, ".target"}, a.tgt, h.tgt);
         ck({t, ".pc"}, a.pc, h.pc);
         ck({t, ".wreg"}, 32'(a.wreg), 32'(h.wreg));
         ck({t, ".class"}, 32'(a.cls), 32'(h.cls));
         ck({t, ".illegal"}, 32'(ill), 32'(h.cls == 3'd7));
      end
   endtask

   always @(negedge clock) begin
      if (started) begin
         cmp("skid", a0, b0.out_valid, b0.in_ready, b0.illegal_out,
             q0.size() > 0 ? q0[0] : zero_e, q0.size(),
             !rst_last && q0.size() < 2, z0 && q0.size() == 0);
         cmp("nosk", a1, b1.out_valid, b1.in_ready, b1.illegal_out,
             q1.size() > 0 ? q1[0] : zero_e, q1.size(),
             q1.size() == 0 || out_ready, z1 && q1.size() == 0);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic [31:0] plan_w [7] = '{
      32'h00851821, 32'h2402FFFF, 32'h3402FFFF, 32'h3C021234,
      32'h0C100000, 32'h1000FFFF, 32'h00000005
   };
   logic [31:0] plan_p [7] = '{
      32'h00400000, 32'h00400004, 32'h00400008, 32'h0040000C,
      32'h00400000, 32'h00000100, 32'h00400010
   };

   initial begin
      exp_t e;
      int idx, cyc;
      bit acc;
      reset = 1'b1; flush = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1;
      insn = '0; pc = '0;

      e = ref_decode(32'h00851821, 32'h00400000);
      ck("pin.addu.rs", 32'(e.rs), 32'd4);
      ck("pin.addu.rt", 32'(e.rt), 32'd5);
      ck("pin.addu.wreg", 32'(e.wreg), 32'd3);
      ck("pin.addu.class", 32'(e.cls), 32'd0);
      e = ref_decode(32'h2402FFFF, 32'h0);
      ck("pin.addiu.imm", e.imm, 32'hFFFFFFFF);
      ck("pin.addiu.wreg", 32'(e.wreg), 32'd2);
      ck("pin.addiu.class", 32'(e.cls), 32'd1);
      e = ref_decode(32'h3402FFFF, 32'h0);
      ck("pin.ori.imm", e.imm, 32'h0000FFFF);
      e = ref_decode(32'h3C021234, 32'h0);
      ck("pin.lui.imm", e.imm, 32'h12340000);
      e = ref_decode(32'h0C100000, 32'h00400000);
      ck("pin.jal.target", e.tgt, 32'h00400000);
      ck("pin.jal.wreg", 32'(e.wreg), 32'd31);
      ck("pin.jal.class", 32'(e.cls), 32'd5);
      e = ref_decode(32'h1000FFFF, 32'h100);
      ck("pin.beq.target", e.tgt, 32'h100);
      ck("pin.beq.class", 32'(e.cls), 32'd4);
      e = ref_decode(32'h00000005, 32'h0);
      ck("pin.illegal.class", 32'(e.cls), 32'd7);

      repeat (3) step();
      started = 1'b1;
      ck("rst.skid.in_ready", 32'(b0.in_ready), 32'd0);
      ck("rst.skid.out_valid", 32'(b0.out_valid), 32'd0);
      ck("rst.skid.imm", b0.imm_out, 32'd0);
      reset = 1'b0;
      step();
      ck("post_rst.skid.in_ready", 32'(b0.in_ready), 32'd1);

      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         insn = plan_w[i];
         pc   = plan_p[i];
         step();
         if (i == 0) begin
            ck("addu.out_valid", 32'(b0.out_valid), 32'd1);
            ck("addu.rs", 32'(b0.rs_out), 32'd4);
            ck("addu.rt", 32'(b0.rt_out), 32'd5);
            ck("addu.rd", 32'(b0.rd_out), 32'd3);
            ck("addu.wreg", 32'(b0.wreg_out), 32'd3);
            ck("addu.pc", b0.pc_out, 32'h00400000);
         end
      end
      in_valid = 1'b0;
      repeat (2) step();

      // four-entry stream with a three-cycle stall at the output
      idx = 0;
      cyc = 0;
      in_valid = 1'b1;
      while (idx < 4 && cyc < 20) begin
         insn = plan_w[idx + 1];
         pc   = 32'h1000 + 32'(idx) * 32'd4;
         out_ready = (cyc >= 3);
         acc = b0.in_ready;
         if (cyc == 2) ck("stream.full.in_ready", 32'(acc), 32'd0);
         step();
         if (acc) idx++;
         cyc++;
      end
      ck("stream.accepted", 32'(idx), 32'd4);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();

      // flush while full, with a competing offer
      in_valid = 1'b1;
      out_ready = 1'b0;
      insn = 32'h2402FFFF; pc = 32'h1800;
      step();
      insn = 32'h3402FFFF; pc = 32'h1804;
      step();
      flush = 1'b1;
      out_ready = 1'b1;
      insn = 32'h3C021234; pc = 32'h1808;
      step();
      flush = 1'b0;
      ck("flush.skid.out_valid", 32'(b0.out_valid), 32'd0);
      ck("flush.nosk.out_valid", 32'(b1.out_valid), 32'd0);
      insn = 32'h00851821; pc = 32'h2000;
      step();
      ck("after_flush.rd", 32'(b0.rd_out), 32'd3);
      ck("after_flush.pc", b0.pc_out, 32'h2000);
      ck("after_flush.nosk.pc", b1.pc_out, 32'h2000);

      // reset in the middle of a stall
      out_ready = 1'b0;
      insn = 32'h0C100000; pc = 32'h00400000;
      step();
      insn = 32'h1000FFFF; pc = 32'h100;
      step();
      reset = 1'b1;
      step();
      ck("mid_rst.out_valid", 32'(b0.out_valid), 32'd0);
      ck("mid_rst.pc", b0.pc_out, 32'd0);
      ck("mid_rst.target", b0.target_out, 32'd0);
      ck("mid_rst.class", 32'(b0.class_out), 32'd0);
      ck("mid_rst.nosk.wreg", 32'(b1.wreg_out), 32'd0);
      reset = 1'b0;
      out_ready = 1'b1;
      step();

      // back-to-back ADDU with the consumer always ready
      for (int i = 0; i < 6; i++) begin
         insn = 32'h00851821;
         pc = 32'h00400000 + 32'(i) * 32'd4;
         step();
      end

      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 4) < 3);
         flush     = ($urandom_range(0, 49) == 0);
         reset     = ($urandom_range(0, 199) == 0);
         insn      = rand_insn();
         pc        = ($urandom_range(0, 7) == 0) ?
                     (32'hFFFFFFF0 | (32'($urandom_range(0, 3)) << 2)) :
                     ($urandom & 32'hFFFFFFFC);
         step();
      end

      in_valid = 1'b0; out_ready = 1'b1;
      flush = 1'b0; reset = 1'b0;
      for (int i = 0; i < 10 && (b0.out_valid || b1.out_valid); i++)
         step();
      ck("drain.out_valid", 32'({b0.out_valid, b1.out_valid}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
